mux_arb_nto1: RTL and testbench

Parametrised N-input, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It succeeds the lab's fixed 3-to-1 combinational mux. It adds selectable fixed-select or round-robin arbitration, and a one-entry output register so that downstream logic sees a stable, registered word. It sits between multiple producer blocks and a single shared consumer, such as a shared ALU operand bus or a result writeback port.

---
 rtl/mux_arb_nto1.sv | 77 +++++++
 tb/tb_mux_arb_nto1.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_nto1.sv
// N-input registered mux with valid/ready on every port; fixed-select or
// round-robin arbitration feeding a one-entry output register.
module mux_arb_nto1 #(
  parameter  int N  = 3,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  grant
);

  logic [N-1:0][W-1:0] lane_data;
  logic [SW-1:0]       ptr;
  logic [SW-1:0]       choice;
  logic                choice_vld;
  logic                can_load;
  logic                xfer;

  assign lane_data = in_data;
  assign can_load  = !out_valid || out_ready;
  // rst_n gating keeps in_ready low for the whole reset window
  assign xfer      = choice_vld && can_load && rst_n;

  always_comb begin
    int idx;
    idx        = 0;
    choice_vld = 1'b0;
    choice     = '0;
    if (mode) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!choice_vld && in_valid[idx]) begin
          choice_vld = 1'b1;
          choice     = SW'(idx);
        end
      end
    end else begin
      // compare against each legal index so sel >= N simply never matches
      for (int i = 0; i < N; i++) begin
        if (sel == SW'(i) && in_valid[i]) begin
          choice_vld = 1'b1;
          choice     = SW'(i);
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign in_ready[i] = xfer && (choice == SW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      grant     <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_data  <= lane_data[choice];
      out_valid <= 1'b1;
      grant     <= choice;
      ptr       <= (choice == SW'(N-1)) ? '0 : choice + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Scoreboard bench for mux_arb_nto1: driver predicts each accepted word from a
// queue-free arbitration model; a monitor checks words as the consumer takes them.
module tb_mux_arb_nto1;
  localparam int N  = 3;
  localparam int W  = 8;
  localparam int SW = 2;

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] grant;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  grant;

  logic [W-1:0] ch [N];
  exp_t         sbq [$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           m_ptr;
  bit           m_occ;
  logic [N-1:0] v, acc;

  mux_arb_nto1 #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = ch[i];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Called at a negedge: apply inputs, predict, then advance to the next negedge.
  task automatic step(input bit md, input int s, input logic [N-1:0] vin,
                      input bit ordy, output logic [N-1:0] accepted);
    int c;
    bit cl;
    mode = md; sel = s[SW-1:0]; in_valid = vin; out_ready = ordy;
    #1;
    cl = !m_occ || ordy;
    c  = -1;
    if (md) begin
      for (int k = 0; k < N; k++)
        if (c < 0 && vin[(m_ptr + k) % N]) c = (m_ptr + k) % N;
    end else if (s < N && vin[s]) begin
      c = s;
    end
    accepted = (c >= 0 && cl) ? N'(1 << c) : '0;
    chk("out_valid", 32'(out_valid), 32'(m_occ));
    chk("in_ready", 32'(in_ready), 32'(accepted));
    if (c >= 0 && cl) begin
      sbq.push_back('{ch[c], c[SW-1:0]});
      m_ptr = (c + 1) % N;
      m_occ = 1'b1;
    end else if (ordy) begin
      m_occ = 1'b0;
    end
    @(negedge clk);
  endtask

  // Pulse reset strictly between edges and confirm the outputs clear at once.
  task automatic pulse_reset();
    @(posedge clk);
    #3;
    in_valid = '1; out_ready = 1'b1; rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    sbq.delete();
    m_ptr = 0;
    m_occ = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: a word is consumed when out_valid && out_ready before an edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_word", 32'(out_data), 32'hxxxx_xxxx);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("grant", 32'(grant), 32'(e.grant));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = '1; mode = 1'b0; sel = '0; out_ready = 1'b0;
    ch[0] = 8'hA5; ch[1] = 8'h3C; ch[2] = 8'hFF;
    m_ptr = 0; m_occ = 1'b0;
    #1;
    chk("init_out_valid", 32'(out_valid), 0);
    chk("init_out_data", 32'(out_data), 0);
    chk("init_grant", 32'(grant), 0);
    chk("init_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // fixed select 2,1,0
    step(0, 2, 3'b111, 1, acc);
    step(0, 1, 3'b111, 1, acc);
    step(0, 0, 3'b111, 1, acc);
    step(0, 0, 3'b000, 1, acc);

    // round-robin from ptr 0, then ch1/ch2 only from ptr 2
    pulse_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 3'b111, 1, acc);
    for (int i = 0; i < 4; i++) step(1, 0, 3'b110, 1, acc);
    step(1, 0, 3'b000, 1, acc);

    // backpressure holding 3C, then load on the same draining edge
    step(0, 1, 3'b111, 1, acc);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 3'b111, 0, acc);
      chk("bp_hold_data", 32'(out_data), 32'h3C);
      chk("bp_hold_grant", 32'(grant), 1);
    end
    step(0, 0, 3'b111, 1, acc);
    step(0, 0, 3'b000, 1, acc);

    // out-of-range select never grants; outstanding word drains
    step(0, 2, 3'b111, 1, acc);
    step(0, 3, 3'b111, 1, acc);
    step(0, 3, 3'b111, 1, acc);
    chk("badsel_empty", 32'(out_valid), 0);

    // mid-operation reset with ptr = 2 and a word pending
    pulse_reset();
    step(1, 0, 3'b111, 1, acc);
    step(1, 0, 3'b111, 1, acc);
    step(1, 0, 3'b000, 0, acc);
    pulse_reset();
    step(1, 0, 3'b111, 1, acc);
    chk("post_rst_first_grant", 32'(acc), 32'b001);
    step(1, 0, 3'b000, 1, acc);

    // randomized traffic; producers hold words until accepted
    v = '0; acc = '0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] || acc[i]) begin
          v[i]  = ($urandom_range(0, 2) != 0);
          ch[i] = 8'($urandom);
        end
      end
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), v,
           ($urandom_range(0, 3) != 0), acc);
    end

    for (int i = 0; i < 4; i++) step(1, 0, 3'b000, 1, acc);
    chk("sb_drained", 32'(sbq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
